// File: rtl/res_act_buf_if.sv
// Bus bundle for res_act_buf: write sources, capture/replay addressing, read
// return, occupancy and sticky error status.
interface res_act_buf_if #(
  parameter int P_BINDWIDTH = 64,
  parameter int P_DEPTH     = 1024,
  parameter int P_NSRC      = 2
);
  localparam int P_AW = $clog2(P_DEPTH);
  localparam int P_SW = $clog2(P_NSRC);

  logic [1:0]                    iMode;
  logic [P_SW-1:0]               iSel;
  logic [P_NSRC*P_BINDWIDTH-1:0] iWrData;
  logic                          iWrEn;
  logic [P_AW-1:0]               iWrAddr;
  logic                          iWrMask;
  logic                          iRdEn;
  logic [P_AW-1:0]               iRdAddr;
  logic                          iRdMask;
  logic [P_BINDWIDTH-1:0]        oRdData;
  logic                          oRdValid;
  logic                          iClear;
  logic [P_AW:0]                 oCount;
  logic                          oDupErr;
  logic                          oMissErr;
  logic                          iErrClr;

  modport master (
    output iMode, iSel, iWrData, iWrEn, iWrAddr, iWrMask,
           iRdEn, iRdAddr, iRdMask, iClear, iErrClr,
    input  oRdData, oRdValid, oCount, oDupErr, oMissErr
  );

  modport slave (
    input  iMode, iSel, iWrData, iWrEn, iWrAddr, iWrMask,
           iRdEn, iRdAddr, iRdMask, iClear, iErrClr,
    output oRdData, oRdValid, oCount, oDupErr, oMissErr
  );
endinterface

// File: rtl/res_act_buf.sv
// Activation/residual input buffer: pass-through latch, write-once residual
// capture store with valid flags, and zero-padded replay through a 2-stage read pipe.
module res_act_buf #(
  parameter int P_BINDWIDTH = 64,
  parameter int P_DEPTH     = 1024,
  parameter int P_AW        = $clog2(P_DEPTH),
  parameter int P_NSRC      = 2,
  parameter int P_SW        = $clog2(P_NSRC)
) (
  input logic          clk,
  input logic          Rst,
  res_act_buf_if.slave bus
);
  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_CAP    = 2'b01;
  localparam logic [1:0] MODE_REPLAY = 2'b10;

  typedef enum logic [1:0] {SEL_ZERO, SEL_BUF, SEL_MEM} outSel_e;

  logic [P_SW-1:0]        sel;
  logic [P_BINDWIDTH-1:0] wData, rBuf, buf2, memRd, rdData;
  logic [P_BINDWIDTH-1:0] mem [P_DEPTH];
  logic [P_DEPTH-1:0]     validQ;
  logic [P_AW:0]          cnt;
  logic                   dupErr, missErr;
  logic [2:1]             vldPipe;
  logic [1:0]             s1Mode;
  logic [P_AW-1:0]        s1Addr;
  logic                   s1Mask;
  outSel_e                s2Sel, nextSel;
  logic                   capWr, newWr, dupSet, rdMem, missSet;

  assign sel = bus.iSel;

  // Out-of-range selects fall back to source 0.
  always_comb begin
    wData = bus.iWrData[0 +: P_BINDWIDTH];
    for (int k = 1; k < P_NSRC; k++)
      if (int'(sel) == k) wData = bus.iWrData[k*P_BINDWIDTH +: P_BINDWIDTH];
  end

  // Clear wins over a same-edge capture: write dropped, no duplicate flagged.
  assign capWr   = (bus.iMode == MODE_CAP) && bus.iWrEn && !bus.iWrMask && !bus.iClear;
  assign newWr   = capWr && !validQ[bus.iWrAddr];
  assign dupSet  = capWr && validQ[bus.iWrAddr];
  assign rdMem   = vldPipe[1] && (s1Mode == MODE_REPLAY) && !s1Mask;
  assign missSet = rdMem && !validQ[s1Addr];

  always_comb begin
    nextSel = SEL_ZERO;
    if (vldPipe[1]) begin
      unique case (s1Mode)
        MODE_PASS:   nextSel = SEL_BUF;
        MODE_REPLAY: nextSel = (!s1Mask && validQ[s1Addr]) ? SEL_MEM : SEL_ZERO;
        default:     nextSel = SEL_ZERO;
      endcase
    end
  end

  // Storage array kept reset-free with a registered read so it can map to SRAM.
  always_ff @(posedge clk) begin
    if (newWr) mem[bus.iWrAddr] <= wData;
    if (rdMem) memRd <= mem[s1Addr];
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rBuf    <= '0;
      buf2    <= '0;
      validQ  <= '0;
      cnt     <= '0;
      dupErr  <= 1'b0;
      missErr <= 1'b0;
      vldPipe <= '0;
      s1Mode  <= '0;
      s1Addr  <= '0;
      s1Mask  <= 1'b0;
      s2Sel   <= SEL_ZERO;
    end else begin
      if (bus.iMode == MODE_PASS && bus.iWrEn) rBuf <= wData;
      if (bus.iClear) begin
        validQ <= '0;
        cnt    <= '0;
      end else if (newWr) begin
        validQ[bus.iWrAddr] <= 1'b1;
        cnt                 <= cnt + (P_AW+1)'(1);
      end
      dupErr  <= dupSet  | (dupErr  & ~bus.iErrClr);
      missErr <= missSet | (missErr & ~bus.iErrClr);
      vldPipe <= {vldPipe[1], bus.iRdEn};
      s1Mode  <= bus.iMode;
      s1Addr  <= bus.iRdAddr;
      s1Mask  <= bus.iRdMask;
      s2Sel   <= nextSel;
      buf2    <= rBuf;
    end
  end

  always_comb begin
    unique case (s2Sel)
      SEL_BUF: rdData = buf2;
      SEL_MEM: rdData = memRd;
      default: rdData = '0;
    endcase
  end

  assign bus.oRdData  = rdData;
  assign bus.oRdValid = vldPipe[2];
  assign bus.oCount   = cnt;
  assign bus.oDupErr  = dupErr;
  assign bus.oMissErr = missErr;
endmodule

// File: tb/tb_res_act_buf.sv
// Scoreboard bench for res_act_buf: directed scenarios plus random traffic
// against a queue/array reference model.
module tb_res_act_buf;
  localparam int W  = 64;
  localparam int D  = 16;
  localparam int NS = 3;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  logic Rst = 1'b0;
  always #5 clk = ~clk;

  res_act_buf_if #(.P_BINDWIDTH(W), .P_DEPTH(D), .P_NSRC(NS)) bus();
  res_act_buf #(.P_BINDWIDTH(W), .P_DEPTH(D), .P_NSRC(NS)) dut (.clk(clk), .Rst(Rst), .bus(bus));

  typedef struct {logic v; logic [1:0] mode; int addr; logic mask;} rd_t;

  int         nChecks = 0;
  int         nErrors = 0;
  logic [W-1:0] sbQ[$];
  logic [W-1:0] refBuf;
  logic [W-1:0] refMem [D];
  logic [W-1:0] fillData [D];
  logic       refValid [D];
  int         refCount;
  logic       refDup, refMiss;
  rd_t        pend;
  logic [W-1:0] srcs [NS];
  logic [W-1:0] monExp;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    refBuf = '0;
    for (int i = 0; i < D; i++) refValid[i] = 1'b0;
    refCount = 0;
    refDup = 1'b0;
    refMiss = 1'b0;
    pend.v = 1'b0;
    sbQ.delete();
  endtask

  task automatic packSrc();
    bus.iWrData = {srcs[2], srcs[1], srcs[0]};
  endtask

  task automatic randSrc();
    for (int k = 0; k < NS; k++) srcs[k] = {$urandom(), $urandom()};
    packSrc();
  endtask

  task automatic setIdle();
    bus.iMode = 2'b11; bus.iSel = '0; bus.iWrEn = 1'b0; bus.iWrAddr = '0;
    bus.iWrMask = 1'b0; bus.iRdEn = 1'b0; bus.iRdAddr = '0; bus.iRdMask = 1'b0;
    bus.iClear = 1'b0; bus.iErrClr = 1'b0;
  endtask

  // One clock: resolve last cycle's read against pre-edge state, then apply this cycle's writes.
  task automatic tick();
    logic [1:0] m;
    int sel, wa, ra;
    logic we, wm, re, rm, clr, ec, dupSet, missSet;
    logic [W-1:0] wd, exp;
    m = bus.iMode; sel = int'(bus.iSel); we = bus.iWrEn; wa = int'(bus.iWrAddr);
    wm = bus.iWrMask; re = bus.iRdEn; ra = int'(bus.iRdAddr); rm = bus.iRdMask;
    clr = bus.iClear; ec = bus.iErrClr;
    wd = (sel < NS) ? srcs[sel] : srcs[0];
    @(posedge clk);
    dupSet = 1'b0;
    missSet = 1'b0;
    if (pend.v) begin
      exp = '0;
      if (pend.mode == 2'b00) exp = refBuf;
      else if (pend.mode == 2'b10 && !pend.mask) begin
        if (refValid[pend.addr]) exp = refMem[pend.addr];
        else missSet = 1'b1;
      end
      sbQ.push_back(exp);
    end
    if (m == 2'b00 && we) refBuf = wd;
    if (clr) begin
      for (int i = 0; i < D; i++) refValid[i] = 1'b0;
      refCount = 0;
    end else if (m == 2'b01 && we && !wm) begin
      if (refValid[wa]) dupSet = 1'b1;
      else begin
        refMem[wa] = wd;
        refValid[wa] = 1'b1;
        refCount++;
      end
    end
    refDup  = dupSet  || (refDup  && !ec);
    refMiss = missSet || (refMiss && !ec);
    pend.v = re; pend.mode = m; pend.addr = ra; pend.mask = rm;
    #1;
  endtask

  always @(negedge clk) begin
    if (!Rst) begin
      chk("count", W'(bus.oCount), W'(refCount));
      chk("dup_err", W'(bus.oDupErr), W'(refDup));
      chk("miss_err", W'(bus.oMissErr), W'(refMiss));
      if (bus.oRdValid) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("FAIL rd_valid: got oRdValid=1 expected 0 (no read pending)");
        end else begin
          monExp = sbQ.pop_front();
          chk("rd_data", bus.oRdData, monExp);
        end
      end
    end
  end

  initial begin
    modelReset();
    setIdle();
    for (int k = 0; k < NS; k++) srcs[k] = '0;
    packSrc();
    #2 Rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    chk("rst_valid", W'(bus.oRdValid), '0);
    chk("rst_data", bus.oRdData, '0);
    chk("rst_count", W'(bus.oCount), '0);
    chk("rst_dup", W'(bus.oDupErr), '0);
    chk("rst_miss", W'(bus.oMissErr), '0);

    // Pass-through from source 1, 2-cycle read latency
    bus.iMode = 2'b00; bus.iSel = 2'd1;
    srcs[0] = {16{4'h5, 4'hA}}; srcs[1] = {16{4'hA, 4'h5}}; srcs[2] = {$urandom(), $urandom()};
    packSrc();
    bus.iWrEn = 1'b1; tick();
    bus.iWrEn = 1'b0; bus.iRdEn = 1'b1; tick();
    bus.iRdEn = 1'b0;
    chk("pass_lat_n1", W'(bus.oRdValid), '0);
    tick();
    chk("pass_lat_n2", W'(bus.oRdValid), W'(1));
    chk("pass_data", bus.oRdData, {16{4'hA, 4'h5}});

    // Write-once capture, duplicate flagged, first value kept
    bus.iMode = 2'b01; bus.iSel = 2'd0; bus.iWrAddr = AW'(5); bus.iWrEn = 1'b1;
    srcs[0] = 64'h11; packSrc(); tick();
    srcs[0] = 64'h22; packSrc(); tick();
    bus.iWrEn = 1'b0; bus.iMode = 2'b10; bus.iRdEn = 1'b1; bus.iRdAddr = AW'(5); tick();
    bus.iRdEn = 1'b0; tick();
    chk("cap_first_kept", bus.oRdData, 64'h11);
    chk("cap_dup", W'(bus.oDupErr), W'(1));
    chk("cap_count", W'(bus.oCount), W'(1));

    // Masked read is silent; unwritten unmasked read flags a miss
    bus.iRdEn = 1'b1; bus.iRdAddr = AW'(7); bus.iRdMask = 1'b1; tick();
    bus.iRdAddr = AW'(9); bus.iRdMask = 1'b0; tick();
    chk("mask_no_miss", W'(bus.oMissErr), '0);
    bus.iRdEn = 1'b0; tick();
    chk("miss_set", W'(bus.oMissErr), W'(1));
    chk("miss_data", bus.oRdData, '0);
    bus.iErrClr = 1'b1; tick();
    bus.iErrClr = 1'b0;
    chk("errclr_dup", W'(bus.oDupErr), '0);
    chk("errclr_miss", W'(bus.oMissErr), '0);

    // Fill whole store, then stream every entry back
    bus.iClear = 1'b1; tick();
    bus.iClear = 1'b0; bus.iMode = 2'b01; bus.iWrEn = 1'b1;
    for (int a = 0; a < D; a++) begin
      fillData[a] = {$urandom(), $urandom()};
      srcs[0] = fillData[a]; packSrc();
      bus.iWrAddr = AW'(a); tick();
    end
    bus.iWrEn = 1'b0;
    chk("full_count", W'(bus.oCount), W'(D));
    bus.iMode = 2'b10;
    for (int i = 0; i <= D; i++) begin
      bus.iRdEn = (i < D); bus.iRdAddr = AW'(i % D); tick();
      if (i >= 1) chk("stream_valid", W'(bus.oRdValid), W'(1));
    end
    bus.iRdEn = 1'b0;

    // Clear beats a same-cycle capture; a read issued just before still sees old data
    bus.iRdEn = 1'b1; bus.iRdAddr = AW'(3); tick();
    bus.iRdEn = 1'b0; bus.iMode = 2'b01; bus.iWrEn = 1'b1; bus.iWrAddr = AW'(3);
    srcs[0] = 64'hDEAD; packSrc(); bus.iClear = 1'b1; tick();
    bus.iClear = 1'b0; bus.iWrEn = 1'b0;
    chk("clr_old_valid", W'(bus.oRdValid), W'(1));
    chk("clr_old_data", bus.oRdData, fillData[3]);
    chk("clr_count", W'(bus.oCount), '0);
    chk("clr_no_dup", W'(bus.oDupErr), '0);
    bus.iMode = 2'b10; bus.iRdEn = 1'b1; tick();
    bus.iRdEn = 1'b0; tick();
    chk("clr_miss", W'(bus.oMissErr), W'(1));
    chk("clr_read_zero", bus.oRdData, '0);

    // Reset with reads in flight
    bus.iErrClr = 1'b1; tick();
    bus.iErrClr = 1'b0; bus.iMode = 2'b01; bus.iWrEn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      randSrc(); bus.iWrAddr = AW'(a); tick();
    end
    bus.iWrEn = 1'b0;
    chk("pre_rst_count", W'(bus.oCount), W'(4));
    bus.iMode = 2'b10; bus.iRdEn = 1'b1; bus.iRdAddr = AW'(0); tick();
    bus.iRdAddr = AW'(1); tick();
    bus.iRdEn = 1'b0;
    Rst = 1'b1;
    modelReset();
    #1;
    chk("rst_fly_valid", W'(bus.oRdValid), '0);
    chk("rst_fly_data", bus.oRdData, '0);
    chk("rst_fly_count", W'(bus.oCount), '0);
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    setIdle();
    repeat (4) tick();
    chk("post_rst_count", W'(bus.oCount), '0);

    // Random traffic
    repeat (800) begin
      bus.iMode   = 2'($urandom_range(0, 3));
      bus.iSel    = 2'($urandom_range(0, 3));
      randSrc();
      bus.iWrEn   = 1'($urandom_range(0, 1));
      bus.iWrAddr = AW'($urandom_range(0, D-1));
      bus.iWrMask = ($urandom_range(0, 3) == 0);
      bus.iRdEn   = 1'($urandom_range(0, 1));
      bus.iRdAddr = AW'($urandom_range(0, D-1));
      bus.iRdMask = ($urandom_range(0, 4) == 0);
      bus.iClear  = ($urandom_range(0, 40) == 0);
      bus.iErrClr = ($urandom_range(0, 8) == 0);
      tick();
    end
    setIdle();
    repeat (3) tick();
    chk("sb_drain", W'(sbQ.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
